// File: rtl/stream_arb_mux_pkg.sv
// Shared types and elaboration helpers for the stream arbiter mux.
package stream_arb_mux_pkg;

  typedef enum logic {
    PRIO_RR    = 1'b0,
    PRIO_FIXED = 1'b1
  } prio_mode_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // Index width never collapses to zero, even for a degenerate channel count.
  function automatic int sel_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/stream_arb_mux_if.sv
// Producer-side and consumer-side handshake bundle for stream_arb_mux.
interface stream_arb_mux_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
);
  localparam int SEL_W = stream_arb_mux_pkg::sel_w(NUM_CH);

  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_last;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_sel;
  logic                     out_last;
  logic                     out_ready;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_last
  );
endinterface

// File: rtl/stream_arb_mux_rr_arbiter.sv
// Combinational channel picker: packet lock, then fixed priority or round-robin from ptr.
module rr_arbiter
  import stream_arb_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = sel_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  prio_mode_e        mode,
  input  logic              lock,
  input  logic [SEL_W-1:0]  lock_ch,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  gidx
);
  localparam int IW = SEL_W + 1;

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    if (lock) begin
      if (req[lock_ch]) begin
        grant[lock_ch] = 1'b1;
        gidx           = lock_ch;
      end
    end else if (mode == PRIO_FIXED) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!found && req[i]) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          gidx     = SEL_W'(i);
        end
      end
    end else begin
      // Walk ptr, ptr+1, ... wrapping at NUM_CH; first requester wins.
      for (int k = 0; k < NUM_CH; k++) begin
        idx = {1'b0, ptr} + IW'(k);
        if (idx >= IW'(NUM_CH)) idx = idx - IW'(NUM_CH);
        if (!found && req[idx[SEL_W-1:0]]) begin
          found                  = 1'b1;
          grant[idx[SEL_W-1:0]]  = 1'b1;
          gidx                   = idx[SEL_W-1:0];
        end
      end
    end
  end
endmodule

// File: rtl/stream_arb_mux.sv
// N-channel valid/ready stream mux with internal arbitration and a one-deep output register.
// Define STREAM_ARB_MUX_PKT_LOCK_EN to hold the grant on one channel until its in_last beat.
module stream_arb_mux
  import stream_arb_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = sel_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prio_mode,
  stream_arb_mux_if.slave   bus
);
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_sel_q,   out_sel_d;
  logic              out_last_q,  out_last_d;
  logic [SEL_W-1:0]  ptr_q,       ptr_d;

  logic              load, xfer, lock, beat_last;
  logic [SEL_W-1:0]  lock_ch, gidx;
  logic [NUM_CH-1:0] grant;
  logic [DATA_W-1:0] beat_data;
  prio_mode_e        mode_eff;

`ifdef STREAM_ARB_MUX_PKT_LOCK_EN
  logic              lock_q,      lock_d;
  logic [SEL_W-1:0]  lock_ch_q,   lock_ch_d;
  prio_mode_e        lock_mode_q, lock_mode_d;

  // Mode seen at lock time stays in force until the packet ends.
  assign lock     = lock_q;
  assign lock_ch  = lock_ch_q;
  assign mode_eff = lock_q ? lock_mode_q : prio_mode_e'(prio_mode);
`else
  assign lock     = 1'b0;
  assign lock_ch  = '0;
  assign mode_eff = prio_mode_e'(prio_mode);
`endif

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req     (bus.in_valid),
    .ptr     (ptr_q),
    .mode    (mode_eff),
    .lock    (lock),
    .lock_ch (lock_ch),
    .grant   (grant),
    .gidx    (gidx)
  );

  assign load         = ~out_valid_q | bus.out_ready;
  assign xfer         = rst_n & load & (|grant);
  assign bus.in_ready = rst_n ? (grant & {NUM_CH{load}}) : '0;

  always_comb begin
    beat_data = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (grant[i]) beat_data = bus.in_data[i*DATA_W +: DATA_W];
  end
  assign beat_last = |(bus.in_last & grant);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_last_d  = out_last_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = beat_data;
        out_sel_d  = gidx;
        out_last_d = beat_last;
      end
    end
    if (xfer && mode_eff == PRIO_RR)
      ptr_d = (gidx == SEL_W'(NUM_CH - 1)) ? '0 : gidx + SEL_W'(1);
  end

`ifdef STREAM_ARB_MUX_PKT_LOCK_EN
  always_comb begin
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
    lock_mode_d = lock_mode_q;
    if (xfer) begin
      lock_d    = ~beat_last;
      lock_ch_d = gidx;
      if (!lock_q) lock_mode_d = prio_mode_e'(prio_mode);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
      ptr_q       <= '0;
`ifdef STREAM_ARB_MUX_PKT_LOCK_EN
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
      lock_mode_q <= PRIO_RR;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_last_q  <= out_last_d;
      ptr_q       <= ptr_d;
`ifdef STREAM_ARB_MUX_PKT_LOCK_EN
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
      lock_mode_q <= lock_mode_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed vector bench for stream_arb_mux (NUM_CH=4, DATA_W=8); honours STREAM_ARB_MUX_PKT_LOCK_EN.
module tb_stream_arb_mux;
  logic clk, rst_n, prio_mode;
  int   n_vec, n_bad;

  stream_arb_mux_if #(.NUM_CH(4), .DATA_W(8)) bus ();

  stream_arb_mux #(.NUM_CH(4), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prio_mode (prio_mode),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        prio;
    logic [3:0]  vld;
    logic [31:0] data;
    logic [3:0]  last;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [7:0]  exp_od;
    logic [1:0]  exp_sel;
    logic        exp_ol;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic p, input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                     input logic r, input logic [3:0] er, input logic ov, input logic [7:0] od,
                     input logic [1:0] es, input logic ol);
    vec_t x;
    x = '{p, v, d, l, r, er, ov, od, es, ol};
    tv.push_back(x);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic p, input logic [3:0] v, input logic [31:0] d,
                       input logic [3:0] l, input logic r);
    prio_mode     = p;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = r;
  endtask

  function automatic logic [15:0] outs();
    return {4'b0, bus.out_valid, bus.out_data, bus.out_sel, bus.out_last};
  endfunction

  localparam logic [31:0] D_RR = 32'hD3C2_B1A0;
  localparam logic [31:0] D_A5 = 32'h4433_22A5;
  localparam logic [31:0] D_BP = 32'h8877_6655;
  localparam logic [31:0] D_PK = 32'h00C2_00A0;

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(1'b0, 4'b1111, D_RR, 4'b1111, 1'b1);

    // Round-robin sweep, all requesting
    for (int k = 0; k < 8; k++) begin
      logic [7:0] b;
      b = D_RR[8*(k%4) +: 8];
      add(0, 4'b1111, D_RR, 4'b1111, 1, 4'(1 << (k%4)), 1, b, 2'(k%4), 1);
    end
    // Fixed priority: ch1 beats ch3 every cycle
    for (int k = 0; k < 3; k++)
      add(1, 4'b1010, D_RR, 4'b1111, 1, 4'b0010, 1, 8'hB1, 2'd1, 1);
    // Load A5, stall three cycles, then release
    add(0, 4'b0001, D_A5, 4'b1111, 1, 4'b0001, 1, 8'hA5, 2'd0, 1);
    for (int k = 0; k < 3; k++)
      add(0, 4'b1111, D_BP, 4'b1111, 0, 4'b0000, 1, 8'hA5, 2'd0, 1);
    add(0, 4'b1111, D_BP, 4'b1111, 1, 4'b0010, 1, 8'h66, 2'd1, 1);
    // Drain: valid drops, data registers hold
    add(0, 4'b0000, D_BP, 4'b1111, 1, 4'b0000, 0, 8'h66, 2'd1, 1);
    add(0, 4'b0000, D_BP, 4'b1111, 0, 4'b0000, 0, 8'h66, 2'd1, 1);
    // Three-beat packet on ch2 while ch0 keeps requesting (ptr starts at 2)
`ifdef STREAM_ARB_MUX_PKT_LOCK_EN
    add(0, 4'b0101, D_PK, 4'b0001, 1, 4'b0100, 1, 8'hC2, 2'd2, 0);
    add(0, 4'b0101, D_PK, 4'b0001, 1, 4'b0100, 1, 8'hC2, 2'd2, 0);
    add(0, 4'b0101, D_PK, 4'b0101, 1, 4'b0100, 1, 8'hC2, 2'd2, 1);
    add(0, 4'b0101, D_PK, 4'b0101, 1, 4'b0001, 1, 8'hA0, 2'd0, 1);
`else
    add(0, 4'b0101, D_PK, 4'b0001, 1, 4'b0100, 1, 8'hC2, 2'd2, 0);
    add(0, 4'b0101, D_PK, 4'b0001, 1, 4'b0001, 1, 8'hA0, 2'd0, 1);
    add(0, 4'b0101, D_PK, 4'b0101, 1, 4'b0100, 1, 8'hC2, 2'd2, 1);
    add(0, 4'b0101, D_PK, 4'b0101, 1, 4'b0001, 1, 8'hA0, 2'd0, 1);
`endif

    // Reset held with all channels requesting
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", {12'b0, bus.in_ready}, 16'h0000);
    chk("rst outs", outs(), 16'h0000);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      drive(tv[i].prio, tv[i].vld, tv[i].data, tv[i].last, tv[i].ordy);
      #1;
      chk($sformatf("v%0d in_ready", i), {12'b0, bus.in_ready}, {12'b0, tv[i].exp_rdy});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d outs", i), outs(),
          {4'b0, tv[i].exp_ov, tv[i].exp_od, tv[i].exp_sel, tv[i].exp_ol});
      @(negedge clk);
    end

    // Mid-packet reset: ptr=1 here, ch1 beat with last=0 (locks when enabled)
    drive(1'b0, 4'b1111, D_RR, 4'b0000, 1'b1);
    @(posedge clk);
    #1;
    chk("pre-rst outs", outs(), {4'b0, 1'b1, 8'hB1, 2'd1, 1'b0});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", {15'b0, bus.out_valid}, 16'h0000);
    chk("async rst in_ready", {12'b0, bus.in_ready}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_last = 4'b1111;
    #1;
    chk("post-rst in_ready", {12'b0, bus.in_ready}, 16'h0001);
    @(posedge clk);
    #1;
    chk("post-rst outs", outs(), {4'b0, 1'b1, 8'hA0, 2'd0, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
